// File: rtl/video_alpha_window_core.sv
// Alpha-blends a constant colour into a rectangular window of a valid/ready
// video stream. Shadow registers commit at frame origin so frames never tear.
package vga_pkg;
  localparam int H_SIZE = 10;
  localparam int V_SIZE = 10;
  typedef struct packed {
    logic [H_SIZE-1:0] hc;
    logic [V_SIZE-1:0] vc;
    logic              frame_start;
  } vga_fc_t;
endpackage

// One colour channel: registered products, truncating add on the output.
module video_alpha_window_ch #(
  parameter int CW = 4,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_adv,
  input  logic [CW-1:0] i_col,
  input  logic [CW-1:0] i_pix,
  input  logic [AW:0]   i_a,
  output logic [CW-1:0] o_pix
);
  localparam int PW = CW + AW + 1;

  logic [PW-1:0] r_pc, r_pp;
  logic [AW:0]   w_ia;

  assign w_ia = (AW+1)'(1 << AW) - i_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
      r_pp <= '0;
    end else if (i_adv) begin
      r_pc <= PW'(i_col) * PW'(i_a);
      r_pp <= PW'(i_pix) * PW'(w_ia);
    end
  end

  assign o_pix = CW'((r_pc + r_pp) >> AW);
endmodule

module video_alpha_window_core
  import vga_pkg::*;
#(
  parameter int RSIZE    = 4,
  parameter int GSIZE    = 4,
  parameter int BSIZE    = 4,
  parameter int RGB_SIZE = 12,
  parameter int ALPHA_W  = 4,
  parameter int PIPELINE = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                avs_write,
  input  logic [2:0]          avs_address,
  input  logic [31:0]         avs_writedata,
  input  logic                src_vld,
  output logic                src_rdy,
  input  logic [RGB_SIZE-1:0] src_rgb,
  input  vga_fc_t             src_fc,
  output logic                snk_vld,
  input  logic                snk_rdy,
  output logic [RGB_SIZE-1:0] snk_rgb,
  output vga_fc_t             snk_fc
);
  logic [2:0]          r_sh_ctrl, r_ctrl;
  logic [RGB_SIZE-1:0] r_sh_color, r_color;
  logic [ALPHA_W-1:0]  r_sh_alpha, r_alpha;
  logic [H_SIZE-1:0]   r_sh_x0, r_sh_x1, r_x0, r_x1;
  logic [V_SIZE-1:0]   r_sh_y0, r_sh_y1, r_y0, r_y1;

  logic                w_adv, w_accept, w_commit, w_hit, w_blend;
  logic                w_en, w_inv;
  logic [RGB_SIZE-1:0] w_color;
  logic [ALPHA_W-1:0]  w_alpha;
  logic [H_SIZE-1:0]   w_x0, w_x1;
  logic [V_SIZE-1:0]   w_y0, w_y1;
  logic [ALPHA_W:0]    w_a_full, w_a;
  logic                w_unused_wdata;

  logic [PIPELINE:1]                    r_vld;
  vga_fc_t [PIPELINE:1]                 r_fc;
  logic [PIPELINE-1:1][RGB_SIZE-1:0]    r_pix, r_col;
  logic [PIPELINE-1:1][ALPHA_W:0]       r_a;

  assign w_unused_wdata = ^avs_writedata;

  assign snk_vld  = r_vld[PIPELINE];
  assign snk_fc   = r_fc[PIPELINE];
  assign w_adv    = !snk_vld || snk_rdy;
  assign src_rdy  = w_adv;
  assign w_accept = src_vld && w_adv;
  assign w_commit = r_ctrl[2] ||
                    (w_accept && (src_fc.frame_start || (src_fc.hc == '0 && src_fc.vc == '0)));

  // The committing beat already sees the values being committed.
  assign w_en    = w_commit ? r_sh_ctrl[0] : r_ctrl[0];
  assign w_inv   = w_commit ? r_sh_ctrl[1] : r_ctrl[1];
  assign w_color = w_commit ? r_sh_color   : r_color;
  assign w_alpha = w_commit ? r_sh_alpha   : r_alpha;
  assign w_x0    = w_commit ? r_sh_x0      : r_x0;
  assign w_x1    = w_commit ? r_sh_x1      : r_x1;
  assign w_y0    = w_commit ? r_sh_y0      : r_y0;
  assign w_y1    = w_commit ? r_sh_y1      : r_y1;

  assign w_hit    = (src_fc.hc >= w_x0) && (src_fc.hc <= w_x1) &&
                    (src_fc.vc >= w_y0) && (src_fc.vc <= w_y1);
  assign w_blend  = w_en && (w_hit ^ w_inv);
  assign w_a_full = (w_alpha == '1) ? (ALPHA_W+1)'(1 << ALPHA_W) : {1'b0, w_alpha};
  // A zero alpha makes the blend an exact pass-through, so no separate bypass mux.
  assign w_a      = w_blend ? w_a_full : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_ctrl  <= '0;
      r_sh_color <= '0;
      r_sh_alpha <= '0;
      r_sh_x0    <= '0;
      r_sh_x1    <= '1;
      r_sh_y0    <= '0;
      r_sh_y1    <= '1;
    end else if (avs_write) begin
      case (avs_address)
        3'd0: r_sh_ctrl  <= avs_writedata[2:0];
        3'd1: r_sh_color <= avs_writedata[RGB_SIZE-1:0];
        3'd2: r_sh_alpha <= avs_writedata[ALPHA_W-1:0];
        3'd3: r_sh_x0    <= avs_writedata[H_SIZE-1:0];
        3'd4: r_sh_x1    <= avs_writedata[H_SIZE-1:0];
        3'd5: r_sh_y0    <= avs_writedata[V_SIZE-1:0];
        3'd6: r_sh_y1    <= avs_writedata[V_SIZE-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl  <= '0;
      r_color <= '0;
      r_alpha <= '0;
      r_x0    <= '0;
      r_x1    <= '1;
      r_y0    <= '0;
      r_y1    <= '1;
    end else if (w_commit) begin
      r_ctrl  <= r_sh_ctrl;
      r_color <= r_sh_color;
      r_alpha <= r_sh_alpha;
      r_x0    <= r_sh_x0;
      r_x1    <= r_sh_x1;
      r_y0    <= r_sh_y0;
      r_y1    <= r_sh_y1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_fc  <= '0;
      r_pix <= '0;
      r_col <= '0;
      r_a   <= '0;
    end else if (w_adv) begin
      r_vld    <= {r_vld[PIPELINE-1:1], src_vld};
      r_fc[1]  <= src_fc;
      r_pix[1] <= src_rgb;
      r_col[1] <= w_color;
      r_a[1]   <= w_a;
      for (int s = 2; s <= PIPELINE; s++) r_fc[s] <= r_fc[s-1];
      for (int s = 2; s < PIPELINE; s++) begin
        r_pix[s] <= r_pix[s-1];
        r_col[s] <= r_col[s-1];
        r_a[s]   <= r_a[s-1];
      end
    end
  end

  logic [RSIZE-1:0] w_r;
  logic [GSIZE-1:0] w_g;
  logic [BSIZE-1:0] w_b;

  video_alpha_window_ch #(.CW(RSIZE), .AW(ALPHA_W)) u_r (
    .clk(clk), .rst_n(rst_n), .i_adv(w_adv),
    .i_col(r_col[PIPELINE-1][RGB_SIZE-1 -: RSIZE]),
    .i_pix(r_pix[PIPELINE-1][RGB_SIZE-1 -: RSIZE]),
    .i_a(r_a[PIPELINE-1]), .o_pix(w_r)
  );
  video_alpha_window_ch #(.CW(GSIZE), .AW(ALPHA_W)) u_g (
    .clk(clk), .rst_n(rst_n), .i_adv(w_adv),
    .i_col(r_col[PIPELINE-1][BSIZE +: GSIZE]),
    .i_pix(r_pix[PIPELINE-1][BSIZE +: GSIZE]),
    .i_a(r_a[PIPELINE-1]), .o_pix(w_g)
  );
  video_alpha_window_ch #(.CW(BSIZE), .AW(ALPHA_W)) u_b (
    .clk(clk), .rst_n(rst_n), .i_adv(w_adv),
    .i_col(r_col[PIPELINE-1][0 +: BSIZE]),
    .i_pix(r_pix[PIPELINE-1][0 +: BSIZE]),
    .i_a(r_a[PIPELINE-1]), .o_pix(w_b)
  );

  assign snk_rgb = {w_r, w_g, w_b};
endmodule
